// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter that shares one sequential multiplier between two requesters.
// Optional build macro MUL_ARBITER_ZERO_BYPASS_EN answers zero-operand requests without the multiplier.
module mul_arbiter #(
    parameter int NUM_BITS    = 4,
    parameter int MUL_LATENCY = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic                  req1_valid,
    input  logic [NUM_BITS-1:0]   req0_a,
    input  logic [NUM_BITS-1:0]   req0_b,
    input  logic [NUM_BITS-1:0]   req1_a,
    input  logic [NUM_BITS-1:0]   req1_b,
    output logic                  req0_ready,
    output logic                  req1_ready,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [2*NUM_BITS-1:0] rsp_product,
    output logic                  mul_rst,
    output logic                  mul_start,
    output logic [NUM_BITS-1:0]   mul_multiplier,
    output logic [NUM_BITS-1:0]   mul_multiplicand,
    input  logic [2*NUM_BITS-1:0] mul_product
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLR   = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [7:0] LAT_LOAD = MUL_LATENCY[7:0];

    logic [2:0]            state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  id_q, id_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [NUM_BITS-1:0]   a_q, a_d;
    logic [NUM_BITS-1:0]   b_q, b_d;
    logic [2*NUM_BITS-1:0] prod_q, prod_d;

    logic                  grant0, grant1;
    logic [NUM_BITS-1:0]   sel_a, sel_b;

    // Ready is gated by rst so no accept strobe can leak out while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE && !rst) begin
            if (req0_valid && (!req1_valid || !ptr_q)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign sel_a = grant1 ? req1_a : req0_a;
    assign sel_b = grant1 ? req1_b : req0_b;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    a_d  = sel_a;
                    b_d  = sel_b;
                    id_d = grant1;
`ifdef MUL_ARBITER_ZERO_BYPASS_EN
                    if (sel_a == '0 || sel_b == '0) begin
                        prod_d  = '0;
                        state_d = DONE;
                    end else begin
                        state_d = CLR;
                    end
`else
                    state_d = CLR;
`endif
                end
            end
            CLR: begin
                state_d = START;
            end
            START: begin
                cnt_d   = LAT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    prod_d  = mul_product;
                    state_d = DONE;
                end
            end
            DONE: begin
                ptr_d   = ~ptr_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            cnt_q   <= 8'd0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
        end
    end

    assign req0_ready       = grant0;
    assign req1_ready       = grant1;
    assign mul_rst          = (state_q == CLR);
    assign mul_start        = (state_q == START);
    assign rsp_valid        = (state_q == DONE);
    assign rsp_id           = id_q;
    assign rsp_product      = prod_q;
    assign mul_multiplier   = a_q;
    assign mul_multiplicand = b_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed self-checking bench for mul_arbiter with a behavioural shared multiplier.
// Expectations follow MUL_ARBITER_ZERO_BYPASS_EN when the bench is built with that macro.
module tb_mul_arbiter;

    localparam int NB  = 4;
    localparam int LAT = 8;
    localparam int PW  = 2 * NB;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [NB-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          req0_ready, req1_ready;
    logic          rsp_valid, rsp_id;
    logic [PW-1:0] rsp_product;
    logic          mul_rst, mul_start;
    logic [NB-1:0] mul_multiplier, mul_multiplicand;
    logic [PW-1:0] mul_product;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int            grant_ids[$];
    int            grant_cyc[$];
    int            rsp_ids[$];
    int            rsp_cyc[$];
    logic [PW-1:0] rsp_prods[$];
    int            n_start, n_mulrst, both_ready, start_cyc, mulrst_cyc;

    mul_arbiter #(.NUM_BITS(NB), .MUL_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product),
        .mul_rst(mul_rst), .mul_start(mul_start),
        .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
        .mul_product(mul_product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shared multiplier model: cleared by mul_rst, product ready one cycle after mul_start.
    always @(posedge clk) begin
        if (rst || mul_rst) mul_product <= '0;
        else if (mul_start) mul_product <= PW'(mul_multiplier) * PW'(mul_multiplicand);
    end

    initial begin
        forever begin
            @(negedge clk);
            if (req0_ready && req1_ready) both_ready++;
            if (req0_ready) begin grant_ids.push_back(0); grant_cyc.push_back(cyc); end
            if (req1_ready) begin grant_ids.push_back(1); grant_cyc.push_back(cyc); end
            if (rsp_valid) begin
                rsp_ids.push_back(int'(rsp_id));
                rsp_prods.push_back(rsp_product);
                rsp_cyc.push_back(cyc);
            end
            if (mul_start) begin n_start++; start_cyc = cyc; end
            if (mul_rst) begin n_mulrst++; mulrst_cyc = cyc; end
        end
    end

    task tick();
        @(posedge clk);
        #1;
    endtask

    task clear_logs();
        grant_ids.delete(); grant_cyc.delete();
        rsp_ids.delete(); rsp_cyc.delete(); rsp_prods.delete();
        n_start = 0; n_mulrst = 0; both_ready = 0; start_cyc = -1; mulrst_cyc = -1;
    endtask

    task wait_grants(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (grant_ids.size() >= n) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task wait_rsps(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rsp_ids.size() >= n) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        clear_logs();
    endtask

    task test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 4'd13; req0_b = 4'd15; req1_a = 4'd3; req1_b = 4'd5;
        repeat (2) @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        checks++;
        if ({rsp_valid, mul_rst, mul_start, rsp_id} !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {rsp_valid, mul_rst, mul_start, rsp_id});
        end
        checks++;
        if ({rsp_product, mul_multiplier, mul_multiplicand} !== '0) begin
            errors++; $display("[TB] FAIL reset_data: got %h/%h/%h expected 0", rsp_product, mul_multiplier, mul_multiplicand);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        rst = 1'b0;
        clear_logs();
        repeat (3) tick();
        checks++;
        if (grant_ids.size() !== 0) begin
            errors++; $display("[TB] FAIL idle_no_grant: got %0d grants expected 0", grant_ids.size());
        end
    endtask

    task test_single();
        bit ok;
        int g;
        clear_logs();
        req0_a = 4'd13; req0_b = 4'd15; req0_valid = 1'b1;
        wait_grants(1, ok);
        req0_valid = 1'b0; req0_a = 4'd2; req0_b = 4'd3;
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL single_grant: got timeout expected grant"); end
        g = grant_cyc[0];
        repeat (4) tick();
        checks++;
        if ({mul_multiplier, mul_multiplicand} !== {4'd13, 4'd15}) begin
            errors++; $display("[TB] FAIL operand_hold: got %0d,%0d expected 13,15", mul_multiplier, mul_multiplicand);
        end
        wait_rsps(1, ok);
        repeat (3) tick();
        checks++;
        if (grant_ids[0] !== 0) begin errors++; $display("[TB] FAIL single_id_grant: got %0d expected 0", grant_ids[0]); end
        checks++;
        if (mulrst_cyc - g !== 1 || start_cyc - g !== 2 || n_start !== 1 || n_mulrst !== 1) begin
            errors++; $display("[TB] FAIL mul_pulses: got rst@+%0d start@+%0d n=%0d/%0d expected +1 +2 n=1/1",
                               mulrst_cyc - g, start_cyc - g, n_mulrst, n_start);
        end
        checks++;
        if (!ok || rsp_cyc[0] - g !== 3 + LAT) begin
            errors++; $display("[TB] FAIL single_latency: got %0d expected %0d", rsp_cyc[0] - g, 3 + LAT);
        end
        checks++;
        if (rsp_ids[0] !== 0 || rsp_prods[0] !== 8'd195) begin
            errors++; $display("[TB] FAIL single_result: got id %0d prod %0d expected id 0 prod 195", rsp_ids[0], rsp_prods[0]);
        end
        checks++;
        if (rsp_product !== 8'd195 || rsp_ids.size() !== 1) begin
            errors++; $display("[TB] FAIL product_hold: got %0d (%0d rsps) expected 195 (1 rsp)", rsp_product, rsp_ids.size());
        end
    endtask

    task test_both();
        bit ok;
        do_reset();
        req0_a = 4'd14; req0_b = 4'd9; req1_a = 4'd1; req1_b = 4'd15;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_grants(1, ok);
        req0_valid = 1'b0;
        wait_grants(2, ok);
        req1_valid = 1'b0;
        wait_rsps(2, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL both_done: got timeout expected 2 responses"); end
        checks++;
        if (grant_ids[0] !== 0 || grant_ids[1] !== 1 || rsp_ids[0] !== 0 || rsp_ids[1] !== 1) begin
            errors++; $display("[TB] FAIL both_order: got grants %0d,%0d rsps %0d,%0d expected 0,1 0,1",
                               grant_ids[0], grant_ids[1], rsp_ids[0], rsp_ids[1]);
        end
        checks++;
        if (rsp_prods[0] !== 8'd126 || rsp_prods[1] !== 8'd15) begin
            errors++; $display("[TB] FAIL both_products: got %0d,%0d expected 126,15", rsp_prods[0], rsp_prods[1]);
        end
        checks++;
        if (rsp_cyc[1] - rsp_cyc[0] !== 4 + LAT) begin
            errors++; $display("[TB] FAIL both_spacing: got %0d expected %0d", rsp_cyc[1] - rsp_cyc[0], 4 + LAT);
        end
    endtask

    task test_alternate();
        bit ok;
        int bad;
        logic [3:0] seq;
        do_reset();
        req0_a = 4'd4; req0_b = 4'd13; req1_a = 4'd4; req1_b = 4'd13;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_grants(4, ok);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsps(4, ok);
        seq = {grant_ids[0][0], grant_ids[1][0], grant_ids[2][0], grant_ids[3][0]};
        checks++;
        if (!ok || seq !== 4'b0101) begin
            errors++; $display("[TB] FAIL alternate_grants: got %b expected 0101", seq);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) if (rsp_prods[i] !== 8'd52) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("[TB] FAIL alternate_products: got %0d wrong expected 0 wrong (52 each)", bad); end
        checks++;
        if (both_ready !== 0) begin errors++; $display("[TB] FAIL one_ready: got %0d double grants expected 0", both_ready); end
    endtask

    task test_zero();
        bit ok;
        int exp_lat, exp_start;
`ifdef MUL_ARBITER_ZERO_BYPASS_EN
        exp_lat = 1; exp_start = 0;
`else
        exp_lat = 3 + LAT; exp_start = 1;
`endif
        clear_logs();
        req1_a = 4'd8; req1_b = 4'd0; req1_valid = 1'b1;
        wait_grants(1, ok);
        req1_valid = 1'b0;
        wait_rsps(1, ok);
        repeat (2) tick();
        checks++;
        if (!ok || grant_ids[0] !== 1 || rsp_ids[0] !== 1 || rsp_prods[0] !== 8'd0) begin
            errors++; $display("[TB] FAIL zero_result: got grant %0d id %0d prod %0d expected 1 1 0",
                               grant_ids[0], rsp_ids[0], rsp_prods[0]);
        end
        checks++;
        if (rsp_cyc[0] - grant_cyc[0] !== exp_lat) begin
            errors++; $display("[TB] FAIL zero_latency: got %0d expected %0d", rsp_cyc[0] - grant_cyc[0], exp_lat);
        end
        checks++;
        if (n_start !== exp_start || n_mulrst !== exp_start) begin
            errors++; $display("[TB] FAIL zero_mul_use: got start %0d rst %0d expected %0d", n_start, n_mulrst, exp_start);
        end
    endtask

    task test_reset_mid();
        bit ok;
        do_reset();
        req0_a = 4'd13; req0_b = 4'd15; req0_valid = 1'b1;
        wait_grants(1, ok);
        req0_valid = 1'b0;
        wait_rsps(1, ok);
        tick();
        clear_logs();
        req0_valid = 1'b1;
        wait_grants(1, ok);
        req0_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({rsp_product, mul_multiplier, mul_multiplicand} !== '0 || {rsp_valid, rsp_id, mul_rst, mul_start} !== 4'b0000) begin
            errors++; $display("[TB] FAIL midreset_outputs: got prod %0d ops %0d,%0d strobes %b expected all 0",
                               rsp_product, mul_multiplier, mul_multiplicand, {rsp_valid, rsp_id, mul_rst, mul_start});
        end
        tick(); tick();
        rst = 1'b0;
        repeat (LAT + 4) tick();
        checks++;
        if (rsp_ids.size() !== 0) begin errors++; $display("[TB] FAIL aborted_rsp: got %0d responses expected 0", rsp_ids.size()); end
        clear_logs();
        req0_a = 4'd13; req0_b = 4'd15; req1_a = 4'd2; req1_b = 4'd3;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_grants(1, ok);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsps(1, ok);
        checks++;
        if (!ok || grant_ids[0] !== 0 || rsp_ids[0] !== 0 || rsp_prods[0] !== 8'd195) begin
            errors++; $display("[TB] FAIL rerequest: got grant %0d id %0d prod %0d expected 0 0 195",
                               grant_ids[0], rsp_ids[0], rsp_prods[0]);
        end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        clear_logs();
        test_reset();
        test_single();
        test_both();
        test_alternate();
        test_zero();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter NUM_BITS, default 4, operand width.
REQ-002 SHALL have parameter MUL_LATENCY, default 8, cycles waited after mul_start before mul_product is sampled; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0_valid, req1_valid  input  1 each  requester has an operation pending.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  NUM_BITS each  multiplier/multiplicand operands.
REQ-007 req0_ready, req1_ready  output  1 each  one-cycle accept strobe; operands are captured in that cycle.
REQ-008 rsp_valid  output  1  one-cycle result strobe.
REQ-009 rsp_id  output  1  requester index owning rsp_product.
REQ-010 rsp_product  output  2*NUM_BITS  result.
REQ-011 mul_rst, mul_start  output  1 each  reset and start for the shared sequential multiplier.
REQ-012 mul_multiplier, mul_multiplicand  output  NUM_BITS each  operands to the multiplier.
REQ-013 mul_product  input  2*NUM_BITS  multiplier result.

Function
REQ-014 SHALL implement FSM states IDLE, CLR, START, WAIT, DONE.
REQ-015 IDLE: no valid -> stay; any valid -> grant one requester, pulse its ready, latch its operands and id, go to CLR.
REQ-016 Arbitration SHALL be round-robin: priority pointer starts at 0; both valid -> the pointer's requester wins; one valid -> that requester wins regardless of pointer.
REQ-017 Pointer SHALL move to the other requester on each DONE.
REQ-018 CLR: mul_rst=1 for exactly one cycle -> START.
REQ-019 START: mul_start=1 for exactly one cycle; counter loaded with MUL_LATENCY -> WAIT.
REQ-020 WAIT: counter decrements each cycle; on the cycle it reaches 1, mul_product SHALL be registered into rsp_product -> DONE.
REQ-021 DONE: rsp_valid=1 and rsp_id=latched id for one cycle -> IDLE.
REQ-022 Latency: with acceptance in cycle t, rsp_valid SHALL be in cycle t+3+MUL_LATENCY; the next grant is no earlier than t+4+MUL_LATENCY.
REQ-023 mul_multiplier/mul_multiplicand SHALL hold the latched operands from CLR through DONE, unchanged by requester inputs.
REQ-024 At most one ready SHALL be high in any cycle; ready SHALL be high only in IDLE.
REQ-025 rsp_product SHALL hold its value until the next capture.
REQ-026 Requester valid deasserting after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-027 rst asserted at any time, including mid-operation, SHALL immediately force IDLE, pointer=0, counter=0, rsp_product=0, rsp_id=0, and all strobes and operand outputs to 0.
REQ-028 An operation aborted by reset SHALL produce no rsp_valid; the requester must re-request.
REQ-029 First grant after rst release SHALL occur no earlier than the first rising edge with rst low.

Configuration
REQ-030 Macro MUL_ARBITER_ZERO_BYPASS_EN defined: an accepted operation with either operand 0 SHALL go IDLE -> DONE, skip CLR/START/WAIT, never pulse mul_rst or mul_start, and return rsp_product=0 with rsp_valid in cycle t+1.
REQ-031 Macro undefined: zero operands SHALL take the normal path and latency of REQ-022.

Verification
REQ-032 Reset, then req0 only with 13x15 -> req0_ready one cycle; mul_rst then mul_start pulses; rsp_valid at t+3+MUL_LATENCY; rsp_id=0; rsp_product=195.
REQ-033 Both requesters valid in the same cycle, 14x9 (req0) and 1x15 (req1) -> req0 served first with 126, then req1 with 15; second response 4+MUL_LATENCY cycles after the first.
REQ-034 Both valid continuously, 4x13 on each -> grants alternate 0,1,0,1; each rsp_product=52; ready never high on both.
REQ-035 req1 with 8x0 -> with bypass macro: rsp_valid at t+1, product 0, no mul_start; without the macro: normal latency, product 0.
REQ-036 Assert rst during WAIT of a 13x15 operation -> outputs zero immediately, no rsp_valid; after release, re-request returns 195 with rsp_id correct and pointer restarted at 0.
